// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: issue/stall controller between the execute stage and the
// multiplier/divider units. Latches one op, launches the selected unit,
// holds the pipeline stalled until the unit reports done (or the watchdog
// fires), then presents a single-cycle writeback.
module multdiv_ctrl #(
  parameter int unsigned MIN_LAT  = 32,
  parameter int unsigned TIMEOUT  = 40,
  parameter int unsigned MULT_EXC = 4,
  parameter int unsigned DIV_EXC  = 5,
  parameter int unsigned TO_EXC   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  op_rd,
  input  logic        flush,
  output logic        stall,
  output logic        mult_start,
  output logic        mult_reset,
  output logic [31:0] mult_mc,
  output logic [31:0] mult_mp,
  input  logic [31:0] mult_prod,
  input  logic        mult_ovf,
  input  logic        mult_done,
  output logic        div_start,
  output logic        div_reset,
  output logic [31:0] div_dvd,
  output logic [31:0] div_dvs,
  input  logic [31:0] div_quot,
  input  logic        div_exc,
  input  logic        div_done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MIN_LAT_C = CNT_W'(MIN_LAT);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [4:0]       EXC_RD    = 5'd30;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_WB     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mult_start_q, mult_start_d;
  logic             div_start_q, div_start_d;
  logic             mult_reset_q, mult_reset_d;
  logic             div_reset_q, div_reset_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             stall_c;
  logic             done_sel;

  // Saturating increment so the counter can never wrap back under MIN_LAT.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == '1) return v;
    return v + 1'b1;
  endfunction

  // Only the launched unit's done is meaningful; the other one is ignored.
  assign done_sel = is_div_q ? div_done : mult_done;

  // Next-state, latch and registered-output logic. The counter is the number
  // of cycles since the start pulse (0 in LAUNCH), so a done is honoured from
  // MIN_LAT cycles after start and the watchdog fires TIMEOUT cycles after it.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    rd_d         = rd_q;
    is_div_d     = is_div_q;
    cnt_d        = cnt_q;
    mult_start_d = 1'b0;
    div_start_d  = 1'b0;
    mult_reset_d = 1'b0;
    div_reset_d  = 1'b0;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    stall_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          stall_c  = 1'b1;
          a_d      = op_a;
          b_d      = op_b;
          rd_d     = op_rd;
          is_div_d = op_is_div;
          cnt_d    = '0;
          if (op_is_div && (op_b == 32'd0)) begin
            // Divide by zero never reaches the divider.
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            wb_rd_d    = EXC_RD;
            wb_data_d  = 32'(DIV_EXC);
          end else begin
            state_d      = S_LAUNCH;
            mult_start_d = !op_is_div;
            div_start_d  = op_is_div;
          end
        end
      end
      S_LAUNCH, S_WAIT: begin
        if (flush) begin
          // Squash: abort the unit next cycle, no writeback.
          state_d      = S_IDLE;
          mult_reset_d = !is_div_q;
          div_reset_d  = is_div_q;
        end else begin
          stall_c = 1'b1;
          cnt_d   = sat_inc(cnt_q);
          if (state_q == S_LAUNCH) begin
            state_d = S_WAIT;
          end else if (done_sel && (cnt_q >= MIN_LAT_C)) begin
            state_d    = S_WB;
            wb_valid_d = 1'b1;
            if (is_div_q) begin
              wb_rd_d   = div_exc ? EXC_RD : rd_q;
              wb_data_d = div_exc ? 32'(DIV_EXC) : div_quot;
            end else begin
              wb_rd_d   = mult_ovf ? EXC_RD : rd_q;
              wb_data_d = mult_ovf ? 32'(MULT_EXC) : mult_prod;
            end
          end else if (cnt_q == TIMEOUT_C) begin
            state_d      = S_WB;
            wb_valid_d   = 1'b1;
            wb_rd_d      = EXC_RD;
            wb_data_d    = 32'(TO_EXC);
            mult_reset_d = !is_div_q;
            div_reset_d  = is_div_q;
          end
        end
      end
      S_WB: begin
        // Writeback completes regardless of flush; new ops wait for IDLE.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, operand latches and registered outputs; async reset clears all.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
      is_div_q     <= 1'b0;
      cnt_q        <= '0;
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      mult_reset_q <= 1'b0;
      div_reset_q  <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rd_q         <= rd_d;
      is_div_q     <= is_div_d;
      cnt_q        <= cnt_d;
      mult_start_q <= mult_start_d;
      div_start_q  <= div_start_d;
      mult_reset_q <= mult_reset_d;
      div_reset_q  <= div_reset_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Stall is combinational so it covers the acceptance cycle; reset forces it low.
  assign stall      = stall_c & ~reset;
  assign mult_start = mult_start_q;
  assign div_start  = div_start_q;
  assign mult_reset = mult_reset_q;
  assign div_reset  = div_reset_q;
  assign mult_mc    = a_q;
  assign mult_mp    = b_q;
  assign div_dvd    = a_q;
  assign div_dvs    = b_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Testbench for multdiv_ctrl: the bench plays the multiplier/divider units
// and compares each op's timing and writeback against a reference model
// derived from the controller's rules.
module tb_multdiv_ctrl;

  localparam int MIN_LAT = 32;
  localparam int TIMEOUT = 40;
  localparam int WIN     = 44;

  typedef struct packed {
    int acc_stall;
    int start_at;
    int mstart;
    int dstart;
    int reset_at;
    int mreset;
    int dreset;
    int wb_at;
    int wb_cnt;
    int stall_cnt;
  } timing_t;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_is_div, flush;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic        stall, mult_start, mult_reset, div_start, div_reset, wb_valid;
  logic [31:0] mult_mc, mult_mp, div_dvd, div_dvs, wb_data;
  logic [4:0]  wb_rd;
  logic [31:0] mult_prod, div_quot;
  logic        mult_ovf, mult_done, div_exc, div_done;

  int n_tests = 0;
  int n_fail  = 0;

  timing_t     obs_t;
  logic [4:0]  obs_rd;
  logic [31:0] obs_data, obs_mc0, obs_mp0, obs_mc_end, obs_mp_end, obs_dvd_end, obs_dvs_end;

  multdiv_ctrl #(.MIN_LAT(MIN_LAT), .TIMEOUT(TIMEOUT), .MULT_EXC(4), .DIV_EXC(5), .TO_EXC(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_is_div(op_is_div),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .flush(flush), .stall(stall),
    .mult_start(mult_start), .mult_reset(mult_reset), .mult_mc(mult_mc), .mult_mp(mult_mp),
    .mult_prod(mult_prod), .mult_ovf(mult_ovf), .mult_done(mult_done),
    .div_start(div_start), .div_reset(div_reset), .div_dvd(div_dvd), .div_dvs(div_dvs),
    .div_quot(div_quot), .div_exc(div_exc), .div_done(div_done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  function automatic string fmt(timing_t t);
    return $sformatf("acc=%0d start@%0d m/d=%0d/%0d rst@%0d m/d=%0d/%0d wb@%0d n=%0d stall=%0d",
                     t.acc_stall, t.start_at, t.mstart, t.dstart, t.reset_at, t.mreset,
                     t.dreset, t.wb_at, t.wb_cnt, t.stall_cnt);
  endfunction

  // Reference timing: cycle indices are relative to the cycle after acceptance.
  function automatic timing_t exp_timing(bit is_div, logic [31:0] b, int done_at, int flush_at);
    timing_t t;
    bit hon;
    int last;
    t = '{acc_stall: 1, start_at: -1, mstart: 0, dstart: 0, reset_at: -1, mreset: 0,
          dreset: 0, wb_at: -1, wb_cnt: 0, stall_cnt: 0};
    if (is_div && b == 32'd0) begin
      t.wb_at = 0; t.wb_cnt = 1;
      return t;
    end
    t.start_at = 0;
    if (is_div) t.dstart = 1; else t.mstart = 1;
    hon  = (done_at >= MIN_LAT) && (done_at <= TIMEOUT);
    last = hon ? done_at : TIMEOUT;
    if (flush_at >= 0 && flush_at <= last) begin
      t.stall_cnt = flush_at;
      t.reset_at  = flush_at + 1;
      if (is_div) t.dreset = 1; else t.mreset = 1;
      return t;
    end
    t.stall_cnt = last + 1;
    t.wb_at     = last + 1;
    t.wb_cnt    = 1;
    if (!hon) begin
      t.reset_at = last + 1;
      if (is_div) t.dreset = 1; else t.mreset = 1;
    end
    return t;
  endfunction

  // Reference writeback value given what the unit returned.
  task automatic exp_wb(input bit is_div, input logic [31:0] b, input logic [4:0] rd,
                        input bit timed_out, input logic [31:0] prod, input bit ovf,
                        input logic [31:0] quot, input bit exc,
                        output logic [4:0] erd, output logic [31:0] edata);
    if (timed_out) begin
      erd = 5'd30; edata = 32'd6;
    end else if (!is_div) begin
      erd = ovf ? 5'd30 : rd; edata = ovf ? 32'd4 : prod;
    end else begin
      erd = (b == 0 || exc) ? 5'd30 : rd; edata = (b == 0 || exc) ? 32'd5 : quot;
    end
  endtask

  // Present one op, then act as the units for 'window' cycles, recording outputs.
  // Selected done pulses at cycle done_at; 'stale' holds it high before MIN_LAT
  // and holds the other unit's done high the whole time.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int done_at, input bit stale,
                        input int flush_at, input int window);
    longint p, q;
    bit sel;
    obs_t = '{acc_stall: 0, start_at: -1, mstart: 0, dstart: 0, reset_at: -1, mreset: 0,
              dreset: 0, wb_at: -1, wb_cnt: 0, stall_cnt: 0};
    obs_rd = 0; obs_data = 0;
    p = longint'($signed(a)) * longint'($signed(b));
    mult_prod = p[31:0];
    mult_ovf  = (p != longint'($signed(p[31:0])));
    if (b == 32'd0) begin
      div_quot = 32'd0; div_exc = 1'b0;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      div_quot = q[31:0];
      div_exc  = (q != longint'($signed(q[31:0])));
    end
    op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
    flush = 1'b0; mult_done = 1'b0; div_done = 1'b0;
    #1 obs_t.acc_stall = int'(stall);
    adv();
    op_valid = 1'b0; op_is_div = 1'($urandom); op_a = $urandom; op_b = $urandom; op_rd = 5'($urandom);
    for (int n = 0; n < window; n++) begin
      flush = (n == flush_at);
      sel = (n == done_at) || (stale && n < MIN_LAT);
      mult_done = is_div ? stale : sel;
      div_done  = is_div ? sel : stale;
      #1;
      if (stall) obs_t.stall_cnt++;
      if (mult_start) begin obs_t.mstart++; if (obs_t.start_at < 0) obs_t.start_at = n; end
      if (div_start)  begin obs_t.dstart++; if (obs_t.start_at < 0) obs_t.start_at = n; end
      if (mult_reset) begin obs_t.mreset++; if (obs_t.reset_at < 0) obs_t.reset_at = n; end
      if (div_reset)  begin obs_t.dreset++; if (obs_t.reset_at < 0) obs_t.reset_at = n; end
      if (wb_valid) begin
        obs_t.wb_cnt++;
        if (obs_t.wb_at < 0) begin obs_t.wb_at = n; obs_rd = wb_rd; obs_data = wb_data; end
      end
      if (n == 0) begin obs_mc0 = mult_mc; obs_mp0 = mult_mp; end
      obs_mc_end = mult_mc; obs_mp_end = mult_mp; obs_dvd_end = div_dvd; obs_dvs_end = div_dvs;
      adv();
    end
    flush = 1'b0; mult_done = 1'b0; div_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [170:0] outs;
    #1 outs = {stall, mult_start, mult_reset, div_start, div_reset, wb_valid, wb_rd, wb_data,
               mult_mc, mult_mp, div_dvd, div_dvs};
    n_tests++;
    if (outs !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, want 0", outs);
    end
    op_valid = 1'b1; #1;
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_stall: got %b, want 0", stall);
    end
    op_valid = 1'b0;
  endtask

  task automatic test_mult_basic();
    timing_t et;
    run_op(1'b0, 32'd7, -32'sd6, 5'd5, MIN_LAT, 1'b0, -1, WIN);
    et = exp_timing(1'b0, -32'sd6, MIN_LAT, -1);
    n_tests++;
    if (obs_t !== et) begin n_fail++; $display("FAIL mult_basic timing: got %s, want %s", fmt(obs_t), fmt(et)); end
    n_tests++;
    if (obs_t.wb_at !== 33 || obs_t.acc_stall !== 1 || obs_t.start_at !== 0) begin
      n_fail++; $display("FAIL mult_basic wb_at/acc/start: got %0d/%0d/%0d, want 33/1/0", obs_t.wb_at, obs_t.acc_stall, obs_t.start_at);
    end
    n_tests++;
    if (obs_rd !== 5'd5 || obs_data !== 32'hFFFFFFD6) begin
      n_fail++; $display("FAIL mult_basic wb: got rd=%0d data=%h, want rd=5 data=ffffffd6", obs_rd, obs_data);
    end
    n_tests++;
    if (obs_mc0 !== 32'd7 || obs_mp0 !== 32'hFFFFFFFA || obs_mc_end !== 32'd7 || obs_dvs_end !== 32'hFFFFFFFA) begin
      n_fail++; $display("FAIL mult_basic operands: got mc=%h mp=%h mc_end=%h dvs_end=%h, want 7/fffffffa", obs_mc0, obs_mp0, obs_mc_end, obs_dvs_end);
    end
  endtask

  task automatic test_mult_ovf();
    timing_t et;
    run_op(1'b0, 32'h00010000, 32'h00010000, 5'd9, 35, 1'b0, -1, WIN);
    et = exp_timing(1'b0, 32'h00010000, 35, -1);
    n_tests++;
    if (obs_t !== et) begin n_fail++; $display("FAIL mult_ovf timing: got %s, want %s", fmt(obs_t), fmt(et)); end
    n_tests++;
    if (obs_rd !== 5'd30 || obs_data !== 32'd4) begin
      n_fail++; $display("FAIL mult_ovf wb: got rd=%0d data=%0d, want rd=30 data=4", obs_rd, obs_data);
    end
  endtask

  task automatic test_div();
    timing_t et;
    run_op(1'b1, 32'd100, 32'd0, 5'd7, MIN_LAT, 1'b0, -1, WIN);
    et = exp_timing(1'b1, 32'd0, MIN_LAT, -1);
    n_tests++;
    if (obs_t !== et) begin n_fail++; $display("FAIL div_zero timing: got %s, want %s", fmt(obs_t), fmt(et)); end
    n_tests++;
    if (obs_t.dstart !== 0 || obs_t.wb_at !== 0 || obs_rd !== 5'd30 || obs_data !== 32'd5) begin
      n_fail++; $display("FAIL div_zero wb: got dstart=%0d wb@%0d rd=%0d data=%0d, want 0/0/30/5", obs_t.dstart, obs_t.wb_at, obs_rd, obs_data);
    end
    run_op(1'b1, -32'sd100, 32'd7, 5'd0, 37, 1'b0, -1, WIN);
    et = exp_timing(1'b1, 32'd7, 37, -1);
    n_tests++;
    if (obs_t !== et) begin n_fail++; $display("FAIL div_basic timing: got %s, want %s", fmt(obs_t), fmt(et)); end
    n_tests++;
    if (obs_rd !== 5'd0 || obs_data !== 32'hFFFFFFF2) begin
      n_fail++; $display("FAIL div_basic wb: got rd=%0d data=%h, want rd=0 data=fffffff2", obs_rd, obs_data);
    end
  endtask

  task automatic test_flush();
    timing_t et;
    run_op(1'b0, 32'd9, 32'd9, 5'd3, MIN_LAT, 1'b0, 10, WIN);
    et = exp_timing(1'b0, 32'd9, MIN_LAT, 10);
    n_tests++;
    if (obs_t !== et || obs_t.reset_at !== 11 || obs_t.wb_cnt !== 0) begin
      n_fail++; $display("FAIL flush_wait: got %s, want %s", fmt(obs_t), fmt(et));
    end
    run_op(1'b0, 32'd3, 32'd4, 5'd12, MIN_LAT, 1'b0, -1, WIN);
    n_tests++;
    if (obs_t.wb_at !== 33 || obs_rd !== 5'd12 || obs_data !== 32'd12) begin
      n_fail++; $display("FAIL flush_after_op: got wb@%0d rd=%0d data=%0d, want 33/12/12", obs_t.wb_at, obs_rd, obs_data);
    end
    run_op(1'b1, 32'd50, 32'd5, 5'd4, 34, 1'b0, 35, WIN);
    n_tests++;
    if (obs_t.wb_at !== 35 || obs_t.dreset !== 0 || obs_rd !== 5'd4 || obs_data !== 32'd10) begin
      n_fail++; $display("FAIL flush_in_wb: got wb@%0d dreset=%0d rd=%0d data=%0d, want 35/0/4/10", obs_t.wb_at, obs_t.dreset, obs_rd, obs_data);
    end
    // flush concurrent with op_valid in IDLE: op must not be accepted
    op_valid = 1'b1; flush = 1'b1; op_is_div = 1'b0; op_a = 32'd77; op_b = 32'd2; #1;
    n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle stall: got %b, want 0", stall); end
    adv();
    op_valid = 1'b0; flush = 1'b0; #1;
    n_tests++;
    if ({mult_start, div_start, stall} !== 3'b000 || mult_mc !== 32'd50) begin
      n_fail++; $display("FAIL flush_idle accept: got start=%b%b stall=%b mc=%0d, want 000 mc=50", mult_start, div_start, stall, mult_mc);
    end
    adv();
  endtask

  task automatic test_timeout();
    timing_t et;
    run_op(1'b0, 32'd5, 32'd6, 5'd8, -1, 1'b1, -1, WIN);
    et = exp_timing(1'b0, 32'd6, -1, -1);
    n_tests++;
    if (obs_t !== et) begin n_fail++; $display("FAIL timeout_stale timing: got %s, want %s", fmt(obs_t), fmt(et)); end
    n_tests++;
    if (obs_t.reset_at !== 41 || obs_t.wb_at !== 41 || obs_rd !== 5'd30 || obs_data !== 32'd6) begin
      n_fail++; $display("FAIL timeout_stale wb: got rst@%0d wb@%0d rd=%0d data=%0d, want 41/41/30/6", obs_t.reset_at, obs_t.wb_at, obs_rd, obs_data);
    end
    run_op(1'b1, 32'd40, 32'd8, 5'd2, MIN_LAT - 1, 1'b0, -1, WIN);
    et = exp_timing(1'b1, 32'd8, MIN_LAT - 1, -1);
    n_tests++;
    if (obs_t !== et || obs_data !== 32'd6) begin
      n_fail++; $display("FAIL early_done: got %s data=%0d, want %s data=6", fmt(obs_t), obs_data, fmt(et));
    end
    run_op(1'b0, 32'd2, 32'd21, 5'd6, TIMEOUT, 1'b0, -1, WIN);
    n_tests++;
    if (obs_t.wb_at !== 41 || obs_t.mreset !== 0 || obs_data !== 32'd42) begin
      n_fail++; $display("FAIL done_at_timeout: got wb@%0d mreset=%0d data=%0d, want 41/0/42", obs_t.wb_at, obs_t.mreset, obs_data);
    end
  endtask

  task automatic test_random();
    timing_t et;
    logic [4:0] erd;
    logic [31:0] edata, a, b;
    bit is_div, stale, to;
    int done_at, flush_at;
    logic [4:0] rd;
    for (int i = 0; i < 14; i++) begin
      is_div = 1'($urandom);
      a = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      b = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      rd = 5'($urandom);
      stale = 1'($urandom);
      case ($urandom_range(0, 3))
        0, 1: done_at = MIN_LAT + $urandom_range(0, TIMEOUT - MIN_LAT);
        2:    done_at = $urandom_range(0, MIN_LAT - 1);
        default: done_at = -1;
      endcase
      flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TIMEOUT + 1) : -1;
      run_op(is_div, a, b, rd, done_at, stale, flush_at, WIN);
      et = exp_timing(is_div, b, done_at, flush_at);
      n_tests++;
      if (obs_t !== et) begin
        n_fail++; $display("FAIL random[%0d] timing: got %s, want %s", i, fmt(obs_t), fmt(et));
      end
      to = (et.reset_at >= 0) && (et.wb_at >= 0);
      exp_wb(is_div, b, rd, to, mult_prod, mult_ovf, div_quot, div_exc, erd, edata);
      if (et.wb_at >= 0) begin
        n_tests++;
        if (obs_rd !== erd || obs_data !== edata) begin
          n_fail++; $display("FAIL random[%0d] wb: got rd=%0d data=%h, want rd=%0d data=%h", i, obs_rd, obs_data, erd, edata);
        end
      end
      n_tests++;
      if (obs_mc_end !== a || obs_mp_end !== b || obs_dvd_end !== a || obs_dvs_end !== b) begin
        n_fail++; $display("FAIL random[%0d] operands: got %h/%h, want %h/%h", i, obs_mc_end, obs_mp_end, a, b);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [170:0] outs;
    bit seen_wb;
    // op held valid through WB is taken only in the following IDLE cycle
    run_op(1'b0, 32'd5, 32'd6, 5'd9, MIN_LAT, 1'b0, -1, MIN_LAT + 1);
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd11; op_b = 32'd13; op_rd = 5'd1; #1;
    n_tests++;
    if (wb_valid !== 1'b1 || stall !== 1'b0 || wb_data !== 32'd30) begin
      n_fail++; $display("FAIL b2b wb_cycle: got wb=%b stall=%b data=%0d, want 1/0/30", wb_valid, stall, wb_data);
    end
    adv(); #1;
    n_tests++;
    if (stall !== 1'b1 || mult_start !== 1'b0 || wb_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b accept_after_wb: got stall=%b start=%b wb=%b, want 1/0/0", stall, mult_start, wb_valid);
    end
    adv(); op_valid = 1'b0; #1;
    n_tests++;
    if (mult_start !== 1'b1 || mult_mc !== 32'd11) begin
      n_fail++; $display("FAIL b2b launch: got start=%b mc=%0d, want 1/11", mult_start, mult_mc);
    end
    repeat (6) adv();
    // asynchronous reset in WAIT: outputs clear without a clock edge
    reset = 1'b1; #1;
    outs = {stall, mult_start, mult_reset, div_start, div_reset, wb_valid, wb_rd, wb_data,
            mult_mc, mult_mp, div_dvd, div_dvs};
    n_tests++;
    if (outs !== '0) begin n_fail++; $display("FAIL async_reset outputs: got %h, want 0", outs); end
    mult_done = 1'b1;
    seen_wb = 1'b0;
    repeat (3) begin adv(); if (wb_valid) seen_wb = 1'b1; end
    reset = 1'b0; mult_done = 1'b0;
    repeat (3) begin adv(); if (wb_valid || stall) seen_wb = 1'b1; end
    n_tests++;
    if (seen_wb !== 1'b0) begin n_fail++; $display("FAIL async_reset no_wb: got activity=%b, want 0", seen_wb); end
    // consecutive ops, each presented the cycle after the prior WB
    run_op(1'b0, 32'd6, 32'd7, 5'd3, MIN_LAT, 1'b0, -1, MIN_LAT + 2);
    n_tests++;
    if (obs_t.wb_at !== 33 || obs_data !== 32'd42) begin
      n_fail++; $display("FAIL b2b first: got wb@%0d data=%0d, want 33/42", obs_t.wb_at, obs_data);
    end
    run_op(1'b1, 32'd81, 32'd9, 5'd4, TIMEOUT - 2, 1'b0, -1, TIMEOUT);
    n_tests++;
    if (obs_t.acc_stall !== 1 || obs_t.start_at !== 0 || obs_t.dstart !== 1 || obs_t.wb_at !== 39 || obs_data !== 32'd9) begin
      n_fail++; $display("FAIL b2b second: got %s data=%0d, want acc=1 start@0 dstart=1 wb@39 data=9", fmt(obs_t), obs_data);
    end
    adv();
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_is_div = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; op_rd = '0;
    mult_prod = '0; mult_ovf = 1'b0; mult_done = 1'b0;
    div_quot = '0; div_exc = 1'b0; div_done = 1'b0;
    repeat (2) adv();
    test_reset();
    reset = 1'b0;
    adv();
    test_mult_basic();
    test_mult_ovf();
    test_div();
    test_flush();
    test_timeout();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
